// File: rtl/cnnip_conv_seq.sv
// Convolution window sequencer: walks output positions and kernel taps,
// feeds a PE with paired pixel/weight reads and writes results in raster order.
//
// Ports:
//   clk_a, arstz_aq          clock, async active-low reset
//   start, kernel_size,      job command and configuration
//   stride
//   busy, done, err          status (done/err are one-cycle pulses)
//   in_* / wt_*              input and weight memory read ports (1-cycle latency)
//   pe_*                     tap stream to the PE and its result return
//   fm_*                     feature memory write port
module cnnip_conv_seq #(
    parameter int IMG_W  = 32,
    parameter int K_MAX  = 7,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk_a,
    input  logic              arstz_aq,
    input  logic              start,
    input  logic [7:0]        kernel_size,
    input  logic [1:0]        stride,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              in_en,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_dout,
    output logic              wt_en,
    output logic [ADDR_W-1:0] wt_addr,
    input  logic [DATA_W-1:0] wt_dout,
    output logic              pe_valid,
    output logic [DATA_W-1:0] pe_pixel,
    output logic [DATA_W-1:0] pe_weight,
    output logic              pe_first,
    output logic              pe_last,
    input  logic [DATA_W-1:0] pe_res,
    input  logic              pe_res_valid,
    output logic              fm_en,
    output logic              fm_we,
    output logic [ADDR_W-1:0] fm_addr,
    output logic [DATA_W-1:0] fm_din
);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] IMG_A = ADDR_W'(IMG_W);
    localparam logic [7:0]        KMX   = 8'(K_MAX);

    state_t            state;
    logic [7:0]        k_q;
    logic [1:0]        s_q;
    logic              err_q;
    logic [ADDR_W-1:0] out_w;
    logic [ADDR_W-1:0] ox;
    logic [ADDR_W-1:0] oy;
    logic [7:0]        kx;
    logic [7:0]        ky;
    logic [ADDR_W-1:0] wr_cnt;
    logic              pe_valid_q;
    logic              pe_first_q;
    logic              pe_last_q;

    logic [ADDR_W-1:0] k_a;
    logic [ADDR_W-1:0] s_a;
    logic [ADDR_W-1:0] kx_a;
    logic [ADDR_W-1:0] ky_a;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] diff;
    logic [ADDR_W-1:0] out_w_c;
    logic [ADDR_W-1:0] total;
    logic [ADDR_W-1:0] wr_nxt;
    logic              legal;
    logic              lkx;
    logic              lky;
    logic              lox;
    logic              loy;

    assign k_a  = ADDR_W'(k_q);
    assign s_a  = ADDR_W'(s_q);
    assign kx_a = ADDR_W'(kx);
    assign ky_a = ADDR_W'(ky);
    assign row  = oy * s_a + ky_a;
    assign col  = ox * s_a + kx_a;

    assign legal = (k_q != 8'd0) && (k_q <= KMX);
    assign diff  = IMG_A - k_a;
    assign total = out_w * out_w;

    // Stride is only ever 1..3 here, so the divide collapses to a small
    // constant-divisor selection.
    always_comb begin
        out_w_c = diff;
        unique case (1'b1)
            (s_q == 2'd2): out_w_c = diff >> 1;
            (s_q == 2'd3): out_w_c = diff / ADDR_W'(3);
            default:       out_w_c = diff;
        endcase
        out_w_c = out_w_c + ADDR_W'(1);
    end

    assign lkx = (kx == k_q - 8'd1);
    assign lky = (ky == k_q - 8'd1);
    assign lox = (ox == out_w - ADDR_W'(1));
    assign loy = (oy == out_w - ADDR_W'(1));

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = done & err_q;

    assign in_en   = (state == RUN);
    assign wt_en   = in_en;
    assign in_addr = in_en ? row * IMG_A + col : '0;
    assign wt_addr = in_en ? ky_a * k_a + kx_a : '0;

    assign pe_valid  = pe_valid_q;
    assign pe_first  = pe_first_q;
    assign pe_last   = pe_last_q;
    assign pe_pixel  = pe_valid_q ? in_dout : '0;
    assign pe_weight = pe_valid_q ? wt_dout : '0;

    assign fm_en   = pe_res_valid && (state != IDLE);
    assign fm_we   = fm_en;
    assign fm_addr = fm_en ? wr_cnt : '0;
    assign fm_din  = fm_en ? pe_res : '0;

    // DRAIN compares against this so a write landing on the check cycle counts.
    assign wr_nxt  = wr_cnt + ADDR_W'(fm_en);

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            state      <= IDLE;
            k_q        <= '0;
            s_q        <= '0;
            err_q      <= 1'b0;
            out_w      <= '0;
            ox         <= '0;
            oy         <= '0;
            kx         <= '0;
            ky         <= '0;
            wr_cnt     <= '0;
            pe_valid_q <= 1'b0;
            pe_first_q <= 1'b0;
            pe_last_q  <= 1'b0;
        end else begin
            pe_valid_q <= in_en;
            pe_first_q <= in_en && (kx == 8'd0) && (ky == 8'd0);
            pe_last_q  <= in_en && lkx && lky;
            if (fm_en) begin
                wr_cnt <= wr_nxt;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k_q   <= kernel_size;
                        s_q   <= (stride == 2'd0) ? 2'd1 : stride;
                        state <= CFG;
                    end
                end
                CFG: begin
                    if (!legal) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        out_w  <= out_w_c;
                        ox     <= '0;
                        oy     <= '0;
                        kx     <= '0;
                        ky     <= '0;
                        wr_cnt <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (!lkx) begin
                        kx <= kx + 8'd1;
                    end else begin
                        kx <= '0;
                        if (!lky) begin
                            ky <= ky + 8'd1;
                        end else begin
                            ky <= '0;
                            if (!lox) begin
                                ox <= ox + ADDR_W'(1);
                            end else begin
                                ox <= '0;
                                if (!loy) begin
                                    oy <= oy + ADDR_W'(1);
                                end else begin
                                    oy    <= '0;
                                    state <= DRAIN;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (wr_nxt == total) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cnnip_conv_seq.md
Name: cnnip_conv_seq

Overview:
- Convolution window sequencer for the CNN IP.
- On a start command it walks every output position of a square IMG_W x IMG_W input image. For each position it walks every kernel tap, issuing paired reads to the input and weight memories.
- It forwards the returned data to the external PE/MAC with first/last tap markers.
- It writes each PE result to the feature memory in raster order, then pulses done.

Parameters:
IMG_W, 32, input image width/height in pixels (square image)
K_MAX, 7, largest legal kernel size
ADDR_W, 12, memory address width
DATA_W, 32, memory data width

Ports:
clk_a  input  1  clock; all logic on rising edge
arstz_aq  input  1  asynchronous, active-low reset
start  input  1  one-cycle command pulse; accepted only in IDLE
kernel_size  input  8  K, kernel width/height; legal range 1..K_MAX
stride  input  2  S; value 0 is treated as 1
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse coincident with done when the configuration is illegal
in_en  output  1  input memory read enable
in_addr  output  ADDR_W  input memory pixel address
in_dout  input  DATA_W  input memory read data, valid exactly 1 cycle after in_en
wt_en  output  1  weight memory read enable
wt_addr  output  ADDR_W  weight memory tap address
wt_dout  input  DATA_W  weight memory read data, valid exactly 1 cycle after wt_en
pe_valid  output  1  pe_pixel/pe_weight hold a valid tap
pe_pixel  output  DATA_W  pixel operand
pe_weight  output  DATA_W  weight operand
pe_first  output  1  first tap of a window (PE clears its accumulator)
pe_last  output  1  last tap of a window
pe_res  input  DATA_W  PE result
pe_res_valid  input  1  result strobe; arbitrary latency, results return in issue order
fm_en  output  1  feature memory enable
fm_we  output  1  feature memory write enable
fm_addr  output  ADDR_W  feature memory write address
fm_din  output  DATA_W  feature memory write data

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, latched configuration 0.
- State IDLE:
  - start=1 latches K=kernel_size and S=(stride==0 ? 1 : stride), then goes to CFG.
  - start is ignored in every other state.
- State CFG (1 cycle):
  - Illegal configuration (K==0 or K>K_MAX): go to DONE with err flag set.
  - Otherwise compute OUT_W=(IMG_W-K)/S+1 (integer division, floor), clear ox, oy, kx, ky and wr_cnt, then go to RUN.
- State RUN, one tap per cycle, no stalls:
  - in_en=wt_en=1.
  - in_addr=(oy*S+ky)*IMG_W+(ox*S+kx).
  - wt_addr=ky*K+kx.
  - Loop nesting, innermost first: kx, ky, ox, oy.
  - On the final tap (kx=ky=K-1, ox=oy=OUT_W-1) go to DRAIN next cycle.
- Tap pipeline:
  - pe_valid, pe_first and pe_last are the registered versions of in_en, (kx==0&&ky==0) and (kx==K-1&&ky==K-1), delayed 1 cycle.
  - pe_pixel=in_dout and pe_weight=wt_dout are passed through in the pe_valid cycle.
- Result write (any state except IDLE):
  - pe_res_valid=1 drives fm_en=fm_we=1, fm_addr=wr_cnt, fm_din=pe_res combinationally in the same cycle, then wr_cnt increments.
  - Results arriving in IDLE are ignored.
- State DRAIN: when wr_cnt==OUT_W*OUT_W, go to DONE.
- State DONE (1 cycle): done=1, err as flagged, then go to IDLE; the err flag clears.
- Arithmetic widths:
  - All address arithmetic is ADDR_W bits unsigned.
  - IMG_W*IMG_W must be <= 2^ADDR_W; this is a design-time constraint.
- Simultaneous events:
  - A result can arrive on the same cycle as the RUN-to-DRAIN transition, or as the write that completes the count. The DRAIN check uses the post-increment count, so done cannot be missed.
- Reset mid-operation: immediate return to IDLE; no done pulse; all enables drop asynchronously.

Test Plan:
- K=5, S=1, PE model with 3-cycle result latency:
  - OUT_W=28; 19600 RUN cycles.
  - First taps: in_addr 0,1,2,3,4,32 and wt_addr 0..5.
  - 784 writes at fm_addr 0..783.
  - done pulses once with err=0.
- K=3, S=2:
  - OUT_W=15; window (ox=1,oy=0) starts at in_addr 2.
  - Window (ox=0,oy=1) starts at in_addr 64.
  - Exactly 225 writes.
- stride=0, K=1:
  - Behaves as S=1; OUT_W=32; 1024 taps, each with pe_first=pe_last=1.
- kernel_size=0, then kernel_size=8:
  - No memory enables; done=err=1 two cycles after start; busy high for exactly those two cycles.
- start re-pulsed during RUN, plus stray pe_res_valid while IDLE:
  - Sequence unaffected; stray result produces no fm_en.
- arstz_aq asserted mid-RUN:
  - All outputs 0 immediately.
  - Next start runs a full K=5 job correctly from fm_addr 0.
